// File: rtl/acc_control.sv
// Multicycle control FSM for the 16-bit accumulator datapath (fetch/decode/mem/exec/write-back).
// Optional stack ops (PUSH/POP, SPDEC/SPINC, SPWrite) are enabled by defining ACC_CTRL_STACK_EN.
module acc_control (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] AddrSel,
    output logic [2:0] SrcA,
    output logic [3:0] SrcB,
    output logic [2:0] ALUOP,
    output logic       PCSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       ACCWrite,
    output logic       SPWrite,
    output logic       ALUOutWrite,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMRD  = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_MEMWR  = 4'd5,
        S_BRANCH = 4'd6,
        S_SPDEC  = 4'd7,
        S_SPINC  = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_PUSH = 4'hA;
    localparam logic [3:0] OP_POP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    state_t     st;
    logic [3:0] op_q;
    logic       op_legal;

    always_comb begin
        op_legal = (Opcode <= OP_JMP) || (Opcode == OP_HALT);
`ifdef ACC_CTRL_STACK_EN
        if (Opcode == OP_PUSH || Opcode == OP_POP) op_legal = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            st   <= S_FETCH;
            op_q <= 4'h0;
        end else begin
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= Opcode;
                    case (Opcode)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4: st <= S_MEMRD;
                        4'h5:                         st <= S_MEMWR;
                        4'h6, 4'h7:                   st <= S_EXEC;
                        4'h8:                         st <= S_BRANCH;
`ifdef ACC_CTRL_STACK_EN
                        4'hA:                         st <= S_SPDEC;
                        4'hB:                         st <= S_MEMRD;
`endif
                        4'hC:                         st <= S_HALT;
                        default:                      st <= S_FETCH;
                    endcase
                end
                S_MEMRD:  if (mem_ready) st <= S_EXEC;
                // POP reuses EXEC to pass MDR into aluOut before bumping SP
                S_EXEC:   st <= (op_q == OP_POP) ? S_SPINC : S_WB;
                S_WB:     st <= S_FETCH;
                S_MEMWR:  if (mem_ready) st <= S_FETCH;
                S_BRANCH: st <= S_FETCH;
                S_SPDEC:  st <= S_MEMWR;
                S_SPINC:  st <= S_WB;
                S_HALT:   st <= S_HALT;
                default:  st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        AddrSel     = 2'd0;
        SrcA        = 3'd0;
        SrcB        = 4'd0;
        ALUOP       = 3'd0;
        PCSrc       = 1'b0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        ACCWrite    = 1'b0;
        SPWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                if (Opcode == OP_JMP) begin
                    PCWrite = 1'b1;
                    SrcB    = 4'd3;
                    ALUOP   = 3'd4;
                end else if (!op_legal) begin
                    illegal = 1'b1;
                end else begin
                    SrcB        = 4'd4;
                    ALUOutWrite = 1'b1;
                end
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                MDRWrite = mem_ready;
`ifdef ACC_CTRL_STACK_EN
                AddrSel  = (op_q == OP_POP) ? 2'd2 : 2'd1;
`else
                AddrSel  = 2'd1;
`endif
            end
            S_EXEC: begin
                SrcA        = 3'd1;
                ALUOutWrite = 1'b1;
                case (op_q)
                    OP_LDI:  begin SrcB = 4'd3; ALUOP = 3'd4; end
                    OP_ADDI: begin SrcB = 4'd1; ALUOP = 3'd0; end
                    OP_LDA, OP_POP: begin SrcB = 4'd2; ALUOP = 3'd4; end
                    default: begin SrcB = 4'd2; ALUOP = op_q[2:0]; end
                endcase
            end
            S_WB: ACCWrite = 1'b1;
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
`ifdef ACC_CTRL_STACK_EN
                AddrSel = (op_q == OP_PUSH) ? 2'd2 : 2'd1;
`else
                AddrSel = 2'd1;
`endif
            end
            S_BRANCH: begin
                SrcA    = 3'd1;
                ALUOP   = 3'd5;
                PCWrite = Zero;
                PCSrc   = Zero;
            end
`ifdef ACC_CTRL_STACK_EN
            S_SPDEC: begin
                SrcA    = 3'd2;
                ALUOP   = 3'd1;
                SPWrite = 1'b1;
            end
            S_SPINC: begin
                SrcA    = 3'd2;
                SPWrite = 1'b1;
            end
`endif
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        // Reset overrides everything so the request drops without waiting for a clock
        if (!reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            AddrSel     = 2'd0;
            SrcA        = 3'd0;
            SrcB        = 4'd0;
            ALUOP       = 3'd0;
            PCSrc       = 1'b0;
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            MDRWrite    = 1'b0;
            ACCWrite    = 1'b0;
            SPWrite     = 1'b0;
            ALUOutWrite = 1'b0;
            halted      = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state = st;

endmodule
